// File: rtl/adc_seq_pkg.sv
// Shared definitions for the sensor acquisition sequencer: state codes,
// sensor indices and the mask scan helper used when picking the next sensor.
package adc_seq_pkg;

  localparam int NUM_SENSORS = 3;

  localparam logic [1:0] TEMP  = 2'd0;
  localparam logic [1:0] SENS1 = 2'd1;
  localparam logic [1:0] SENS2 = 2'd2;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_POWER = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_ACCUM = 3'd4;
  localparam logic [2:0] ST_EMIT  = 3'd5;
  localparam logic [2:0] ST_NEXT  = 3'd6;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } sel_t;

  // Lowest set bit of mask at or above index from (descending scan so the
  // lowest qualifying bit is the last one written).
  function automatic sel_t lowest_set_from(input logic [NUM_SENSORS-1:0] mask,
                                           input logic [2:0] from);
    sel_t r;
    r.found = 1'b0;
    r.idx   = 2'd0;
    for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        r.found = 1'b1;
        r.idx   = 2'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_sample_seq_if.sv
// Analog-side bundle between the sequencer and the SAR ADC / sensor power switches.
interface adc_sample_seq_if;
  import adc_seq_pkg::*;

  // adc_start is a single-cycle request; the ADC answers later by raising
  // adc_eoc (level) with adc_dout valid in every cycle adc_eoc is high.
  // No backpressure: the sequencer only looks at adc_eoc while waiting.
  logic                   adc_start;
  logic [1:0]             adc_mux_sel;
  logic [NUM_SENSORS-1:0] sens_pwr;
  logic                   adc_eoc;
  logic [7:0]             adc_dout;

  modport master (
    output adc_start,
    output adc_mux_sel,
    output sens_pwr,
    input  adc_eoc,
    input  adc_dout
  );

  modport slave (
    input  adc_start,
    input  adc_mux_sel,
    input  sens_pwr,
    output adc_eoc,
    output adc_dout
  );

endinterface

// File: rtl/adc_avg_accum.sv
// Conversion accumulator: sums 2^AVG_SHIFT samples and presents the truncated mean.
module adc_avg_accum #(
  parameter int AVG_SHIFT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       add_en,
  input  logic [7:0] add_val,
  input  logic       clr,
  output logic       full,
  output logic [7:0] avg
);

  localparam int AW = 8 + AVG_SHIFT;
  localparam int CW = AVG_SHIFT + 1;

  logic [AW-1:0] acc;
  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      acc   <= '0;
      count <= '0;
    end else if (add_en) begin
      acc   <= acc + AW'(add_val);
      count <= count + CW'(1);
    end
  end

  assign full = (count == CW'(1 << AVG_SHIFT));
  // The sum of 2^AVG_SHIFT bytes always fits, so the top byte is the mean.
  assign avg  = acc[AVG_SHIFT +: 8];

endmodule

// File: rtl/adc_sample_seq.sv
// Sensor acquisition sequencer: powers each enabled sensor, runs averaged ADC
// conversions and hands one byte per sensor to the tag memory controller.
module adc_sample_seq
  import adc_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int AVG_SHIFT     = 2,
  parameter int EOC_TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  adc_sample_seq_if.master       adc,
  input  logic                   sample_req,
  input  logic [NUM_SENSORS-1:0] senscode,
  input  logic                   tx_enable,
  output logic [7:0]             ADC_data,
  output logic                   ADC_data_ready,
  output logic [1:0]             sensor_id,
  output logic                   busy,
  output logic                   round_done,
  output logic                   err_timeout,
  output logic [2:0]             fsm_state
);

  logic [2:0]             state_q;
  logic [NUM_SENSORS-1:0] mask_q;
  logic [1:0]             cur_q;
  logic [7:0]             settle_cnt;
  logic [7:0]             tmo_cnt;
  logic [7:0]             data_q;
  logic [1:0]             id_q;
  logic                   err_q;
  logic                   done_q;

  sel_t       first_sel;
  sel_t       next_sel;
  logic       powered;
  logic       start_fire;
  logic       emit_fire;
  logic       eoc_hit;
  logic       tmo_hit;
  logic       acc_full;
  logic [7:0] acc_avg;

  assign first_sel = lowest_set_from(senscode, 3'd0);
  assign next_sel  = lowest_set_from(mask_q, {1'b0, cur_q} + 3'd1);

  assign powered = (state_q == ST_POWER) || (state_q == ST_START) ||
                   (state_q == ST_WAIT)  || (state_q == ST_ACCUM) ||
                   (state_q == ST_EMIT);

  // tx_enable gates the pulses combinationally so a same-cycle rise defers them.
  assign start_fire = (state_q == ST_START) && !tx_enable;
  assign emit_fire  = (state_q == ST_EMIT)  && !tx_enable;
  assign eoc_hit    = (state_q == ST_WAIT)  && adc.adc_eoc;
  assign tmo_hit    = (state_q == ST_WAIT)  && !adc.adc_eoc &&
                      (tmo_cnt == 8'(EOC_TIMEOUT - 1));

  adc_avg_accum #(
    .AVG_SHIFT (AVG_SHIFT)
  ) u_accum (
    .clk     (clk),
    .reset   (reset),
    .add_en  (eoc_hit || tmo_hit),
    .add_val (eoc_hit ? adc.adc_dout : 8'h00),
    .clr     (emit_fire || (state_q == ST_IDLE)),
    .full    (acc_full),
    .avg     (acc_avg)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      mask_q     <= '0;
      cur_q      <= 2'd0;
      settle_cnt <= 8'd0;
      tmo_cnt    <= 8'd0;
      data_q     <= 8'h00;
      id_q       <= 2'd0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (emit_fire) begin
        data_q <= acc_avg;
        id_q   <= cur_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (sample_req) begin
            mask_q     <= senscode;
            err_q      <= 1'b0;
            cur_q      <= first_sel.idx;
            settle_cnt <= 8'd0;
            if (first_sel.found) state_q <= ST_POWER;
            else                 done_q  <= 1'b1;
          end
        end
        ST_POWER: begin
          if (settle_cnt == 8'(SETTLE_CYCLES - 1)) state_q <= ST_START;
          else settle_cnt <= settle_cnt + 8'd1;
        end
        ST_START: begin
          if (start_fire) begin
            tmo_cnt <= 8'd0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A real end-of-conversion beats a timeout landing in the same cycle.
          if (eoc_hit) begin
            state_q <= ST_ACCUM;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            state_q <= ST_ACCUM;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        ST_ACCUM: begin
          state_q <= acc_full ? ST_EMIT : ST_START;
        end
        ST_EMIT: begin
          if (emit_fire) state_q <= ST_NEXT;
        end
        ST_NEXT: begin
          if (next_sel.found) begin
            cur_q      <= next_sel.idx;
            settle_cnt <= 8'd0;
            state_q    <= ST_POWER;
          end else begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign adc.adc_start   = start_fire;
  assign adc.sens_pwr    = powered ? (NUM_SENSORS'(1) << cur_q) : '0;
  assign adc.adc_mux_sel = powered ? cur_q : 2'd0;

  // Bypass during the emit cycle so the data is valid alongside the ready pulse.
  assign ADC_data       = emit_fire ? acc_avg : data_q;
  assign sensor_id      = emit_fire ? cur_q : id_q;
  assign ADC_data_ready = emit_fire;
  assign busy           = (state_q != ST_IDLE);
  assign round_done     = done_q;
  assign err_timeout    = err_q;
  assign fsm_state      = state_q;

endmodule

// File: doc/adc_sample_seq.md
# adc_sample_seq

Sensor acquisition sequencer for the tag. It sits directly upstream of the tag memory controller, which consumes its `ADC_data`/`ADC_data_ready` outputs. The tag top supplies `senscode`, and the sequencer then powers each enabled sensor, drives the SAR ADC, averages the conversions, and hands one averaged byte per sensor to the memory controller. While the tag is backscattering, it defers any new ADC activity.

## Interface
Parameters:
- `SETTLE_CYCLES`, 16: clk cycles sensor power is held before the first conversion (1..255).
- `AVG_SHIFT`, 2: 2^AVG_SHIFT conversions averaged per sensor (0..4).
- `EOC_TIMEOUT`, 255: max clk cycles waiting for `adc_eoc` after `adc_start` (1..255).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-low reset.
- `sample_req`  in  1  one-cycle request to start an acquisition round.
- `senscode`  in  3  sensor enable mask (bit i = sensor i); latched at round start.
- `tx_enable`  in  1  tag transmitting; holds off new conversions and emits.
- `adc_eoc`  in  1  ADC end-of-conversion, level, synchronous to clk.
- `adc_dout`  in  8  ADC result, valid while `adc_eoc`=1.
- `adc_start`  out  1  one-cycle conversion start pulse.
- `adc_mux_sel`  out  2  analog mux select = current sensor index (0..2).
- `sens_pwr`  out  3  one-hot sensor power enable.
- `ADC_data`  out  8  averaged result; holds until the next emit.
- `ADC_data_ready`  out  1  one-cycle pulse, `ADC_data` valid.
- `sensor_id`  out  2  sensor index tagging `ADC_data`.
- `busy`  out  1  round in progress (state != IDLE).
- `round_done`  out  1  one-cycle pulse at end of round.
- `err_timeout`  out  1  sticky conversion-timeout flag; cleared on accepted `sample_req`.

## Operation
- **States:** IDLE, POWER, START, WAIT_EOC, ACCUM, EMIT, NEXT.
- **IDLE:**
  - `sample_req`=1 latches `senscode` into `mask_q`, clears `err_timeout`, and selects the lowest set bit of `mask_q` as `cur`.
  - If `mask_q`==0, pulse `round_done` next cycle and stay in IDLE.
  - Otherwise go to POWER.
- **POWER:** `sens_pwr`=1<<`cur`, `adc_mux_sel`=`cur`. Stay for exactly SETTLE_CYCLES cycles, then go to START.
- **START:**
  - If `tx_enable`=1, wait here with no pulse.
  - Otherwise pulse `adc_start` for one cycle, clear the timeout counter, and go to WAIT_EOC.
- **WAIT_EOC:**
  - `adc_eoc`=1: add `adc_dout` to the accumulator (width 8+AVG_SHIFT, zero-extended), increment the sample count, and go to ACCUM.
  - Timeout counter reaching EOC_TIMEOUT: set `err_timeout`, add 0 to the accumulator, and go to ACCUM.
- **ACCUM:** if the sample count == 2^AVG_SHIFT, go to EMIT; else go to START. No power-down between conversions.
- **EMIT:**
  - If `tx_enable`=1, wait here.
  - Otherwise `ADC_data` = accumulator >> AVG_SHIFT (truncating; max 8'hFF, no overflow), `sensor_id`=`cur`, pulse `ADC_data_ready`, clear the accumulator and count, and go to NEXT.
- **NEXT:**
  - Deassert `sens_pwr`.
  - If a higher set bit remains in `mask_q`, set `cur` to it and go to POWER (full settle again).
  - Otherwise pulse `round_done` and go to IDLE.
- **Ignored inputs:** `sample_req` while `busy`=1 is ignored. `senscode` changes mid-round are ignored.
- **`adc_eoc` outside WAIT_EOC** is ignored.

## Timing
- **Reset values (`reset`=0 at a clk edge):** all outputs 0, `ADC_data`=8'h00, state IDLE, accumulator/counters 0. Reset mid-round aborts immediately: `sens_pwr` drops the next cycle and no emit occurs.
- **Round start latency:** `sample_req` sampled at edge N gives `sens_pwr` high from N+1; first `adc_start` at cycle N+1+SETTLE_CYCLES (with `tx_enable`=0).
- **Conversion capture:** `adc_eoc` seen at edge M gives ACCUM at M+1. The next `adc_start` is at M+2, or EMIT is at M+2 with `ADC_data_ready` high during M+2.
- **Per-sensor minimum cycles:** SETTLE_CYCLES + 2^AVG_SHIFT·(3 + eoc latency) + 1.
- **Timeout:** the timeout fires after exactly EOC_TIMEOUT cycles in WAIT_EOC without `adc_eoc`.
- **Simultaneous events:**
  - `adc_eoc` and timeout in the same cycle: `adc_eoc` wins, no error.
  - `tx_enable` rising in the same cycle as START/EMIT: that action is deferred.
- **Output hold:** `ADC_data`/`sensor_id` are stable from the emit cycle until the next emit.

## Structure
- **Shared package `adc_seq_pkg`:** state enum, NUM_SENSORS=3, sensor index constants (TEMP=0, SENS1=1, SENS2=2), and a lowest-set-bit-above function used by IDLE/NEXT.
- **Sub-module `adc_avg_accum`:** accumulator, sample counter, shift/truncate output, and clear. Parameterised by AVG_SHIFT.
- **Top of the block:** FSM, settle counter and timeout counter.

## Test plan
- **All sensors, no averaging:** `senscode`=3'b111, AVG_SHIFT=0, `adc_eoc` 4 cycles after each start with `adc_dout`=8'h10/8'h20/8'h30 -> three `ADC_data_ready` pulses with (`sensor_id`, `ADC_data`)=(0,10h),(1,20h),(2,30h), then `round_done`.
- **Averaging:** AVG_SHIFT=2, `senscode`=3'b010, samples 8'hFF,8'hFF,8'hFE,8'h01 -> single emit `ADC_data`=8'hBF (0x2FD>>2), `sensor_id`=1, `adc_start` pulsed exactly 4 times.
- **Timeout:** `adc_eoc` never asserted, EOC_TIMEOUT=10, AVG_SHIFT=0, `senscode`=3'b001 -> `err_timeout`=1 after 10 cycles in WAIT_EOC, `ADC_data`=8'h00 emitted, round completes; next `sample_req` clears `err_timeout`.
- **Transmit hold-off:** `tx_enable` held high for 50 cycles spanning START -> no `adc_start` while it is high; start occurs the cycle after it falls. Same check at EMIT for `ADC_data_ready`.
- **Empty mask and ignored requests:** `senscode`=0 -> `round_done` 1 cycle after `sample_req`, `sens_pwr` never set. A second `sample_req` while busy -> ignored; exactly one `round_done` for the round.
- **Reset mid-round:** `reset`=0 during WAIT_EOC -> all outputs 0 the next cycle, no `ADC_data_ready`; a fresh round after reset behaves normally.
